// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue, cleared by writeback or flush.
// Priority per bit: flush > set > write-clear > hold; bit 0 never becomes pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]  wr_addr,
  input  logic                       sb_set_en,
  input  logic [AW-1:0]              sb_set_addr,
  input  logic                       sb_flush,
  output logic [NREGS-1:0]           o_pending
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;

  // Next-state of the pending vector with set-over-clear and flush-over-all priority.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        w_pending_nxt[wr_addr[j]] = 1'b0;
      end else begin
        w_pending_nxt = w_pending_nxt;
      end
    end
    if (sb_set_en) begin
      w_pending_nxt[sb_set_addr] = 1'b1;
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
    w_pending_nxt[AW'(REG_ZERO)] = 1'b0;
    if (sb_flush) begin
      w_pending_nxt = '0;
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
  end

  // Pending-bit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered read ports and pending-write scoreboard; x0 reads zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and a cleared busy) to colliding reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]  rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]  wr_data,
  input  logic                         sb_set_en,
  input  logic [AW-1:0]                sb_set_addr,
  input  logic                         sb_flush
);

  logic [XLEN-1:0]             r_regs [NREGS];
  logic [NUM_RD-1:0][XLEN-1:0] r_rd_data;
  logic [NUM_RD-1:0]           r_rd_busy;
  logic [NUM_RD-1:0][XLEN-1:0] w_rd_data;
  logic [NUM_RD-1:0]           w_rd_busy;
  logic [NREGS-1:0]            w_pending;

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_flush    (sb_flush),
    .o_pending   (w_pending)
  );

  // Storage; ascending port loop lets the higher-index write port win a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j] != AW'(REG_ZERO))) begin
          r_regs[wr_addr[j]] <= wr_data[j];
        end
      end
    end
  end

  // Read-side selection: array/scoreboard, optional forwarding, then x0 forced to zero.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_data[i] = r_regs[rd_addr[i]];
      w_rd_busy[i] = w_pending[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j] == rd_addr[i])) begin
          w_rd_data[i] = wr_data[j];
          w_rd_busy[i] = 1'b0;
        end else begin
          w_rd_busy[i] = w_rd_busy[i];
        end
      end
`endif
      if (rd_addr[i] == AW'(REG_ZERO)) begin
        w_rd_data[i] = '0;
        w_rd_busy[i] = 1'b0;
      end else begin
        w_rd_busy[i] = w_rd_busy[i];
      end
    end
  end

  // Read output registers; hold when the port is not strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) begin
          r_rd_data[i] <= w_rd_data[i];
          r_rd_busy[i] <= w_rd_busy[i];
        end
      end
    end
  end

  assign rd_data = r_rd_data;
  assign rd_busy = r_rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 read / 2 write ports): directed table, random vs model, reset.
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] COLL_D = 32'h0000A5A5;
  localparam logic        COLL_B = 1'b0;
  localparam bit          BYPASS = 1'b1;
`else
  localparam logic [31:0] COLL_D = 32'h00000001;
  localparam logic        COLL_B = 1'b1;
  localparam bit          BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_RD-1:0]           rd_en = '0;
  logic [NUM_RD-1:0][AW-1:0]   rd_addr = '0;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_busy;
  logic [NUM_WR-1:0]           wr_en = '0;
  logic [NUM_WR-1:0][AW-1:0]   wr_addr = '0;
  logic [NUM_WR-1:0][XLEN-1:0] wr_data = '0;
  logic                        sb_set_en = 1'b0;
  logic [AW-1:0]               sb_set_addr = '0;
  logic                        sb_flush = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush)
  );

  int total = 0;
  int bad = 0;

  // Reference state: architectural registers, pending flags, last read results.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  logic [31:0] m_d    [2];
  logic        m_b    [2];

  typedef struct {
    logic [1:0] ren; logic [4:0] ra0; logic [4:0] ra1;
    logic [1:0] wen; logic [4:0] wa0; logic [4:0] wa1;
    logic [31:0] wd0; logic [31:0] wd1;
    logic set; logic [4:0] sa; logic fl;
    logic [31:0] ed0; logic eb0; logic [31:0] ed1; logic eb1;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'd0;
      m_pend[r] = 1'b0;
    end
    m_d[0] = 32'd0; m_d[1] = 32'd0; m_b[0] = 1'b0; m_b[1] = 1'b0;
  endtask

  // Apply one clock of the architectural rules to the reference state.
  task automatic model_step();
    logic [31:0] new_regs [32];
    bit          new_pend [32];
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i]) begin
        int a = int'(rd_addr[i]);
        if (a == 0) begin
          m_d[i] = 32'd0; m_b[i] = 1'b0;
        end else begin
          m_d[i] = m_regs[a]; m_b[i] = m_pend[a];
          if (BYPASS) begin
            if (wr_en[1] && int'(wr_addr[1]) == a) begin
              m_d[i] = wr_data[1]; m_b[i] = 1'b0;
            end else if (wr_en[0] && int'(wr_addr[0]) == a) begin
              m_d[i] = wr_data[0]; m_b[i] = 1'b0;
            end
          end
        end
      end
    end
    for (int r = 1; r < 32; r++) begin
      bit hit0 = wr_en[0] && int'(wr_addr[0]) == r;
      bit hit1 = wr_en[1] && int'(wr_addr[1]) == r;
      new_regs[r] = hit1 ? wr_data[1] : (hit0 ? wr_data[0] : m_regs[r]);
      if (sb_flush) new_pend[r] = 1'b0;
      else if (sb_set_en && int'(sb_set_addr) == r) new_pend[r] = 1'b1;
      else if (hit0 || hit1) new_pend[r] = 1'b0;
      else new_pend[r] = m_pend[r];
    end
    for (int r = 1; r < 32; r++) begin
      m_regs[r] = new_regs[r];
      m_pend[r] = new_pend[r];
    end
  endtask

  task automatic drive(input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [1:0] wen, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic set, input logic [4:0] sa, input logic fl);
    rd_en = ren; rd_addr[0] = ra0; rd_addr[1] = ra1;
    wr_en = wen; wr_addr[0] = wa0; wr_addr[1] = wa1;
    wr_data[0] = wd0; wr_data[1] = wd1;
    sb_set_en = set; sb_set_addr = sa; sb_flush = fl;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".d0"}, rd_data[0], m_d[0]);
    chk({tag, ".b0"}, {31'd0, rd_busy[0]}, {31'd0, m_b[0]});
    chk({tag, ".d1"}, rd_data[1], m_d[1]);
    chk({tag, ".b1"}, {31'd0, rd_busy[1]}, {31'd0, m_b[1]});
  endtask

  initial begin
    // Directed sequence; each row is one clock, expectations are the outputs after that edge.
    vecs[0]  = '{2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{2'b11, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{2'b00, 5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{2'b00, 5'd0, 5'd0, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[5]  = '{2'b11, 5'd5, 5'd7, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h22, 1'b0};
    vecs[6]  = '{2'b00, 5'd0, 5'd0, 2'b01, 5'd9, 5'd0, 32'h1, 32'h0, 1'b1, 5'd9, 1'b0, 32'hDEADBEEF, 1'b0, 32'h22, 1'b0};
    vecs[7]  = '{2'b01, 5'd9, 5'd0, 2'b10, 5'd0, 5'd9, 32'h0, 32'hA5A5, 1'b0, 5'd0, 1'b0, COLL_D, COLL_B, 32'h22, 1'b0};
    vecs[8]  = '{2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'hA5A5, 1'b0, 32'h22, 1'b0};
    vecs[9]  = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 32'hA5A5, 1'b0, 32'h22, 1'b0};
    vecs[10] = '{2'b10, 5'd0, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'hA5A5, 1'b0, 32'h0, 1'b1};
    vecs[11] = '{2'b00, 5'd0, 5'd0, 2'b01, 5'd3, 5'd0, 32'h33, 32'h0, 1'b1, 5'd3, 1'b0, 32'hA5A5, 1'b0, 32'h0, 1'b1};
    vecs[12] = '{2'b10, 5'd0, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'hA5A5, 1'b0, 32'h33, 1'b1};
    vecs[13] = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4, 1'b1, 32'hA5A5, 1'b0, 32'h33, 1'b1};
    vecs[14] = '{2'b11, 5'd3, 5'd4, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h33, 1'b0, 32'h0, 1'b0};

    model_reset();
    #2;
    chk("reset.d0", rd_data[0], 32'd0);
    chk("reset.d1", rd_data[1], 32'd0);
    chk("reset.busy", {30'd0, rd_busy}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 16; k++) begin
      drive(2'b11, 5'(2 * k + 1), 5'((2 * k + 2) > 31 ? 31 : (2 * k + 2)), 2'b00, 5'd0, 5'd0,
            32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
      tick();
      chk("init.d0", rd_data[0], 32'd0);
      chk("init.d1", rd_data[1], 32'd0);
      chk("init.busy", {30'd0, rd_busy}, 32'd0);
    end

    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].ren, vecs[v].ra0, vecs[v].ra1, vecs[v].wen, vecs[v].wa0, vecs[v].wa1,
            vecs[v].wd0, vecs[v].wd1, vecs[v].set, vecs[v].sa, vecs[v].fl);
      tick();
      chk($sformatf("vec%0d.d0", v), rd_data[0], vecs[v].ed0);
      chk($sformatf("vec%0d.b0", v), {31'd0, rd_busy[0]}, {31'd0, vecs[v].eb0});
      chk($sformatf("vec%0d.d1", v), rd_data[1], vecs[v].ed1);
      chk($sformatf("vec%0d.b1", v), {31'd0, rd_busy[1]}, {31'd0, vecs[v].eb1});
    end

    // Random traffic on a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0));
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    // Make outputs non-zero, then reset asynchronously mid-cycle with reads active.
    drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 5'd0, 32'h5555, 32'd0, 1'b1, 5'd6, 1'b0);
    tick();
    drive(2'b11, 5'd5, 5'd6, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    tick();
    chk("prerst.d0", rd_data[0], 32'h5555);
    chk("prerst.b1", {31'd0, rd_busy[1]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.d0", rd_data[0], 32'd0);
    chk("arst.busy", {30'd0, rd_busy}, 32'd0);
    model_reset();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      drive(2'b11, 5'(2 * k), 5'(2 * k + 1), 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
      tick();
      check_model($sformatf("postrst%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
